// File: rtl/hamster_pkg.sv
// Shared types and bit mapping for the half-bridge dead-time guard.
package hamster_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      ON_H = 2'd1,
      ON_L = 2'd2
   } phase_state_t;

   // Request decode of the {ls,hs} pair of one phase
   typedef enum logic [1:0] {
      REQ_OFF = 2'b00,
      REQ_H   = 2'b01,
      REQ_L   = 2'b10,
      REQ_ILL = 2'b11
   } phase_req_t;

   localparam int HS_BIT = 0;
   localparam int LS_BIT = 1;

endpackage

// File: rtl/deadtime_phase.sv
// One half-bridge phase: on/off FSM plus dead-time down-counter.
//
// state | meaning
// OFF   | both gates off; counter runs down to 0 before any turn-on
// ON_H  | high side driven
// ON_L  | low side driven
module deadtime_phase
   import hamster_pkg::*;
#(
   parameter int K_DTW = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [1:0]       i_req,
   input  logic             i_force,
   input  logic [K_DTW-1:0] i_deadtime,
   output logic [1:0]       o_gate_nxt,
   output logic             o_busy_nxt
);

   phase_state_t     r_state;
   phase_state_t     w_state_nxt;
   logic [K_DTW-1:0] r_cnt;
   logic [K_DTW-1:0] w_cnt_nxt;
   logic [K_DTW-1:0] w_load;
   phase_req_t       w_req;
   logic             w_cnt_zero;

   assign w_req      = phase_req_t'(i_req);
   assign w_cnt_zero = (r_cnt == '0);

   // Counter holds the off cycles still owed after the current one, so a
   // load of max(deadtime,1)-1 yields exactly max(deadtime,1) all-off cycles.
   assign w_load = (i_deadtime == '0) ? '0 : (i_deadtime - K_DTW'(1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= OFF;
         r_cnt   <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (i_force) begin
         w_state_nxt = OFF;
         w_cnt_nxt   = w_load;
      end else begin
         case (r_state)
            OFF: begin
               if (w_cnt_zero && w_req == REQ_H) begin
                  w_state_nxt = ON_H;
               end else if (w_cnt_zero && w_req == REQ_L) begin
                  w_state_nxt = ON_L;
               end else if (!w_cnt_zero) begin
                  w_cnt_nxt = r_cnt - K_DTW'(1);
               end
            end
            ON_H: begin
               if (w_req != REQ_H) begin
                  w_state_nxt = OFF;
                  w_cnt_nxt   = w_load;
               end
            end
            ON_L: begin
               if (w_req != REQ_L) begin
                  w_state_nxt = OFF;
                  w_cnt_nxt   = w_load;
               end
            end
            default: begin
               w_state_nxt = OFF;
               w_cnt_nxt   = w_load;
            end
         endcase
      end
   end

   always_comb begin
      o_gate_nxt         = 2'b00;
      o_gate_nxt[HS_BIT] = (w_state_nxt == ON_H);
      o_gate_nxt[LS_BIT] = (w_state_nxt == ON_L);
      o_busy_nxt         = (r_state == OFF) && !w_cnt_zero && !i_force &&
                           (w_req == REQ_H || w_req == REQ_L);
   end

endmodule

// File: rtl/bridge_deadtime_guard.sv
// Gate-drive safety stage: per-phase dead time, sticky shoot-through fault,
// enable/fault forcing and registered gate outputs.
module bridge_deadtime_guard
   import hamster_pkg::*;
#(
   parameter int K_NPHASE = 3,
   parameter int K_DTW    = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic [2*K_NPHASE-1:0] i_cmd,
   input  logic [K_DTW-1:0]      i_deadtime,
   input  logic                  i_fault_clr,
   output logic [2*K_NPHASE-1:0] o_gate,
   output logic                  o_fault,
   output logic [K_NPHASE-1:0]   o_busy
);

   logic [2*K_NPHASE-1:0] r_gate;
   logic [K_NPHASE-1:0]   r_busy;
   logic                  r_fault;
   logic [2*K_NPHASE-1:0] w_gate_nxt;
   logic [K_NPHASE-1:0]   w_busy_nxt;
   logic                  w_any_ill;
   logic                  w_force;

   always_comb begin
      w_any_ill = 1'b0;
      for (int p = 0; p < K_NPHASE; p++) begin
         if (phase_req_t'(i_cmd[2*p +: 2]) == REQ_ILL) begin
            w_any_ill = 1'b1;
         end
      end
   end

   // An illegal request blanks every phase in the same cycle the fault latches
   assign w_force = !i_enable || r_fault || w_any_ill;

   for (genvar p = 0; p < K_NPHASE; p++) begin : g_phase
      deadtime_phase #(
         .K_DTW (K_DTW)
      ) u_phase (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_req      (i_cmd[2*p +: 2]),
         .i_force    (w_force),
         .i_deadtime (i_deadtime),
         .o_gate_nxt (w_gate_nxt[2*p +: 2]),
         .o_busy_nxt (w_busy_nxt[p])
      );
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_gate  <= '0;
         r_busy  <= '0;
         r_fault <= 1'b0;
      end else begin
         r_gate <= w_gate_nxt;
         r_busy <= w_busy_nxt;
         if (w_any_ill) begin
            r_fault <= 1'b1;
         end else if (i_fault_clr) begin
            r_fault <= 1'b0;
         end
      end
   end

   assign o_gate  = r_gate;
   assign o_busy  = r_busy;
   assign o_fault = r_fault;

endmodule

// File: tb/tb_bridge_deadtime_guard.sv
// Directed self-checking bench for bridge_deadtime_guard.
module tb_bridge_deadtime_guard;

   logic       clk;
   logic       rst;
   logic       en;
   logic [5:0] cmd;
   logic [7:0] dt;
   logic       clr;
   logic [5:0] gate;
   logic       fault;
   logic [2:0] busy;

   int n_err = 0;
   int n_chk = 0;

   bridge_deadtime_guard #(.K_NPHASE(3), .K_DTW(8)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_enable    (en),
      .i_cmd       (cmd),
      .i_deadtime  (dt),
      .i_fault_clr (clr),
      .o_gate      (gate),
      .o_fault     (fault),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; cmd = 6'b0; dt = 8'd4; clr = 1'b0;
      tick();
      tick();
      n_chk++; if (gate !== 6'b0) begin n_err++; $display("FAIL reset_gate got=%b exp=%b", gate, 6'b0); end
      n_chk++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", fault); end
      n_chk++; if (busy !== 3'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=000", busy); end
   endtask

   // All-ones counter after reset: 255 dead cycles before the first turn-on
   task automatic test_startup();
      int bad;
      bad = 0;
      rst = 1'b0; cmd = 6'b000001; dt = 8'd4;
      for (int i = 1; i <= 255; i++) begin
         tick();
         if (gate !== 6'b0) bad++;
      end
      n_chk++; if (bad != 0) begin n_err++; $display("FAIL startup_wait nonzero_cycles=%0d exp=0", bad); end
      n_chk++; if (busy !== 3'b001) begin n_err++; $display("FAIL startup_busy got=%b exp=001", busy); end
      tick();
      n_chk++; if (gate !== 6'b000001) begin n_err++; $display("FAIL startup_on got=%b exp=000001", gate); end
      n_chk++; if (busy !== 3'b000) begin n_err++; $display("FAIL startup_busy_clear got=%b exp=000", busy); end
   endtask

   // Swap phase 0 sides; expect `zeros` all-off cycles, then the new side
   task automatic test_swap(input logic [5:0] to_cmd, input logic [7:0] d, input int zeros);
      cmd = to_cmd; dt = d;
      for (int i = 0; i < zeros; i++) begin
         tick();
         n_chk++;
         if (gate !== 6'b0) begin
            n_err++; $display("FAIL swap_dead dt=%0d cyc=%0d got=%b exp=000000", d, i, gate);
         end
      end
      tick();
      n_chk++; if (gate !== to_cmd) begin n_err++; $display("FAIL swap_on dt=%0d got=%b exp=%b", d, gate, to_cmd); end
   endtask

   task automatic test_multi();
      cmd = 6'b100110;
      tick();
      n_chk++; if (gate !== 6'b100110) begin n_err++; $display("FAIL multi_on got=%b exp=100110", gate); end
   endtask

   task automatic test_deadtime_change();
      cmd = 6'b101010; dt = 8'd3;
      tick();
      n_chk++; if (gate !== 6'b100010) begin n_err++; $display("FAIL dtchg_off got=%b exp=100010", gate); end
      dt = 8'd200;
      tick();
      n_chk++; if (gate !== 6'b100010) begin n_err++; $display("FAIL dtchg_c2 got=%b exp=100010", gate); end
      n_chk++; if (busy !== 3'b010) begin n_err++; $display("FAIL dtchg_busy got=%b exp=010", busy); end
      tick();
      n_chk++; if (gate !== 6'b100010) begin n_err++; $display("FAIL dtchg_c3 got=%b exp=100010", gate); end
      tick();
      n_chk++; if (gate !== 6'b101010) begin n_err++; $display("FAIL dtchg_on got=%b exp=101010", gate); end
      n_chk++; if (busy !== 3'b000) begin n_err++; $display("FAIL dtchg_busy_clear got=%b exp=000", busy); end
      dt = 8'd2;
   endtask

   task automatic test_fault();
      cmd = 6'b101110;
      tick();
      n_chk++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault_set got=%b exp=1", fault); end
      n_chk++; if (gate !== 6'b0) begin n_err++; $display("FAIL fault_gate got=%b exp=000000", gate); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_chk++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault_clr_blocked got=%b exp=1", fault); end
      cmd = 6'b100010;
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_chk++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_clr got=%b exp=0", fault); end
      n_chk++; if (gate !== 6'b0) begin n_err++; $display("FAIL fault_clr_gate got=%b exp=000000", gate); end
      tick();
      n_chk++; if (gate !== 6'b0) begin n_err++; $display("FAIL fault_resume_dead got=%b exp=000000", gate); end
      tick();
      n_chk++; if (gate !== 6'b100010) begin n_err++; $display("FAIL fault_resume_on got=%b exp=100010", gate); end
   endtask

   task automatic test_enable();
      en = 1'b0;
      tick();
      n_chk++; if (gate !== 6'b0) begin n_err++; $display("FAIL en_off got=%b exp=000000", gate); end
      n_chk++; if (fault !== 1'b0) begin n_err++; $display("FAIL en_fault got=%b exp=0", fault); end
      dt = 8'd3;
      tick();
      en = 1'b1;
      tick();
      n_chk++; if (gate !== 6'b0) begin n_err++; $display("FAIL en_dead1 got=%b exp=000000", gate); end
      tick();
      n_chk++; if (gate !== 6'b0) begin n_err++; $display("FAIL en_dead2 got=%b exp=000000", gate); end
      tick();
      n_chk++; if (gate !== 6'b100010) begin n_err++; $display("FAIL en_on got=%b exp=100010", gate); end
   endtask

   task automatic test_async_reset();
      int bad;
      bad = 0;
      cmd = 6'b100001; dt = 8'd10;
      tick();
      n_chk++; if (gate !== 6'b100000) begin n_err++; $display("FAIL arst_pre got=%b exp=100000", gate); end
      tick();
      #2 rst = 1'b1;
      #1;
      n_chk++; if (gate !== 6'b0) begin n_err++; $display("FAIL arst_gate got=%b exp=000000", gate); end
      n_chk++; if (busy !== 3'b0) begin n_err++; $display("FAIL arst_busy got=%b exp=000", busy); end
      tick();
      rst = 1'b0; cmd = 6'b100010;
      for (int i = 1; i <= 255; i++) begin
         tick();
         if (gate !== 6'b0) bad++;
      end
      n_chk++; if (bad != 0) begin n_err++; $display("FAIL arst_restart nonzero_cycles=%0d exp=0", bad); end
      tick();
      n_chk++; if (gate !== 6'b100010) begin n_err++; $display("FAIL arst_on got=%b exp=100010", gate); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_swap(6'b000010, 8'd5, 5);
      test_swap(6'b000001, 8'd0, 1);
      test_swap(6'b000010, 8'd0, 1);
      test_multi();
      test_deadtime_change();
      test_fault();
      test_enable();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
